spi_slave_receiver: RTL and testbench

- Bit-level receiver for SD-style 48-bit SPI command frames: start(0), transmission(1), 6-bit command index, 32-bit argument, CRC7, end(1).
- Sits behind an SPI shift buffer that presents a sliding 8-bit window plus a "new bit" flag. Runs in the system clock domain.
- Extracts the command index and argument, checks CRC7 and the end bit, and reports progress flags plus its state.

---
 rtl/spi_slave_receiver_if.sv | 25 ++
 rtl/spi_slave_receiver.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_receiver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_receiver_if.sv
// Bus between the SPI shift buffer and the command-frame receiver.
// The buffer side drives the bit window; the receiver side returns the decoded frame.
interface spi_slave_receiver_if;
    logic [7:0]  io_InputBuffer;
    logic        io_BufferChanged;
    logic [7:0]  io_DataBlockSize;
    logic        io_CommandReadFinished;
    logic        io_ArgumentReadFinished;
    logic        io_ReadSuccess;
    logic [5:0]  io_Command;
    logic [31:0] io_CommandArgument;
    logic [2:0]  io____state;

    modport slave (
        input  io_InputBuffer, io_BufferChanged, io_DataBlockSize,
        output io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess,
        output io_Command, io_CommandArgument, io____state
    );

    modport master (
        output io_InputBuffer, io_BufferChanged, io_DataBlockSize,
        input  io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess,
        input  io_Command, io_CommandArgument, io____state
    );
endinterface

// File: rtl/spi_slave_receiver.sv
// Bit-serial receiver for 48-bit SD-style SPI command frames: extracts the
// command index and argument, checks CRC7 and the end bit.
module spi_slave_receiver (
    input  logic                 clock,
    input  logic                 reset,
    spi_slave_receiver_if.slave  bus
);
    localparam int unsigned CMD_W = 6;
    localparam int unsigned ARG_W = 32;
    localparam int unsigned CRC_W = 7;
    localparam int unsigned CNT_W = 6;
    localparam logic [CRC_W-1:0] CRC_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TXBIT = 3'd1,
        ST_CMD   = 3'd2,
        ST_ARG   = 3'd3,
        ST_CRC   = 3'd4,
        ST_END   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic               chg_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   crc_cap_q, crc_cap_d;
    logic               end_bit_q, end_bit_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [ARG_W-1:0]   arg_q, arg_d;
    logic               cmd_done_q, cmd_done_d;
    logic               arg_done_q, arg_done_d;
    logic               success_q, success_d;

    logic               strobe_c;
    logic               bit_c;
    logic [CRC_W-1:0]   crc_next_c;
    logic               unused_c;

    // One bit per rising edge of the buffer-changed flag, however long it stays high.
    assign strobe_c   = bus.io_BufferChanged & ~chg_prev_q;
    assign bit_c      = bus.io_InputBuffer[0];
    assign crc_next_c = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ bit_c) ? CRC_POLY : '0);
    assign unused_c   = ^{bus.io_DataBlockSize, bus.io_InputBuffer[7:1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        crc_cap_d  = crc_cap_q;
        end_bit_d  = end_bit_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        cmd_done_d = cmd_done_q;
        arg_done_d = arg_done_q;
        success_d  = success_q;

        unique case (state_q)
            ST_IDLE: begin
                if (strobe_c && !bit_c) begin
                    state_d    = ST_TXBIT;
                    cmd_done_d = 1'b0;
                    arg_done_d = 1'b0;
                    success_d  = 1'b0;
                    // A zero start bit shifted into a cleared register leaves it zero.
                    crc_d      = '0;
                end
            end
            ST_TXBIT: begin
                if (strobe_c) begin
                    if (bit_c) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                        crc_d   = crc_next_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CMD: begin
                if (strobe_c) begin
                    cmd_d = {cmd_q[CMD_W-2:0], bit_c};
                    crc_d = crc_next_c;
                    if (cnt_q == CNT_W'(CMD_W - 1)) begin
                        cmd_done_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_ARG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ARG: begin
                if (strobe_c) begin
                    arg_d = {arg_q[ARG_W-2:0], bit_c};
                    crc_d = crc_next_c;
                    if (cnt_q == CNT_W'(ARG_W - 1)) begin
                        arg_done_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (strobe_c) begin
                    crc_cap_d = {crc_cap_q[CRC_W-2:0], bit_c};
                    if (cnt_q == CNT_W'(CRC_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_END;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_END: begin
                if (strobe_c) begin
                    end_bit_d = bit_c;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                success_d = (crc_cap_q == crc_q) && end_bit_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            chg_prev_q <= 1'b0;
            cnt_q      <= '0;
            crc_q      <= '0;
            crc_cap_q  <= '0;
            end_bit_q  <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            cmd_done_q <= 1'b0;
            arg_done_q <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            chg_prev_q <= bus.io_BufferChanged;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            crc_cap_q  <= crc_cap_d;
            end_bit_q  <= end_bit_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            cmd_done_q <= cmd_done_d;
            arg_done_q <= arg_done_d;
            success_q  <= success_d;
        end
    end

    assign bus.io_CommandReadFinished  = cmd_done_q;
    assign bus.io_ArgumentReadFinished = arg_done_q;
    assign bus.io_ReadSuccess          = success_q;
    assign bus.io_Command              = cmd_q;
    assign bus.io_CommandArgument      = arg_q;
    assign bus.io____state             = 3'(state_q);
endmodule

// File: tb/tb_spi_slave_receiver.sv
// Self-checking bench for spi_slave_receiver: fixed frame table, corner-case
// sequences and random frames against a polynomial-division CRC model.
module tb_spi_slave_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] win = 8'hFF;
    int n_cmp = 0;
    int n_bad = 0;

    spi_slave_receiver_if bus_if ();

    spi_slave_receiver dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [7:0]  crc_byte;
        logic        exp_success;
    } vec_t;

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] rem;
        rem = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        return rem[6:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.io_BufferChanged = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Shift one bit into the window and hold the changed flag for 'hold' clocks.
    task automatic send_bit(input logic b, input int hold);
        @(negedge clk);
        win = {win[6:0], b};
        bus_if.io_InputBuffer = win;
        bus_if.io_BufferChanged = 1'b1;
        repeat (hold) @(negedge clk);
        bus_if.io_BufferChanged = 1'b0;
    endtask

    task automatic send_bits(input logic [47:0] f, input int hi, input int lo, input int hold);
        for (int i = hi; i >= lo; i--)
            send_bit(f[i], (hold == 0) ? int'($urandom_range(1, 3)) : hold);
    endtask

    task automatic check_frame(input string name, input logic [5:0] cmd, input logic [31:0] arg,
                               input logic succ);
        repeat (2) @(negedge clk);
        check({name, "_cmd"}, 64'(bus_if.io_Command), 64'(cmd));
        check({name, "_arg"}, 64'(bus_if.io_CommandArgument), 64'(arg));
        check({name, "_cmdfin"}, 64'(bus_if.io_CommandReadFinished), 64'd1);
        check({name, "_argfin"}, 64'(bus_if.io_ArgumentReadFinished), 64'd1);
        check({name, "_success"}, 64'(bus_if.io_ReadSuccess), 64'(succ));
        check({name, "_state"}, 64'(bus_if.io____state), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_state"}, 64'(bus_if.io____state), 64'd0);
        check({name, "_cmd"}, 64'(bus_if.io_Command), 64'd0);
        check({name, "_arg"}, 64'(bus_if.io_CommandArgument), 64'd0);
        check({name, "_flags"}, 64'({bus_if.io_CommandReadFinished, bus_if.io_ArgumentReadFinished,
                                     bus_if.io_ReadSuccess}), 64'd0);
    endtask

    initial begin
        vec_t vecs[5];
        logic [47:0] f;

        vecs[0] = '{6'd0,  32'h0000_0000, 8'h95, 1'b1};
        vecs[1] = '{6'd8,  32'h0000_01AA, 8'h87, 1'b1};
        vecs[2] = '{6'd8,  32'h0000_01AA, 8'h89, 1'b0};
        vecs[3] = '{6'd55, 32'h0000_0000, 8'h65, 1'b1};
        vecs[4] = '{6'd8,  32'h0000_01AA, 8'h86, 1'b0};

        bus_if.io_InputBuffer = win;
        bus_if.io_BufferChanged = 1'b0;
        bus_if.io_DataBlockSize = 8'd0;
        do_reset();
        check_all_zero("reset");

        // Idle line: a stream of ones never starts a frame.
        repeat (80) send_bit(1'b1, 1);
        @(negedge clk);
        check_all_zero("idle");

        foreach (vecs[k]) begin
            f = {2'b01, vecs[k].cmd, vecs[k].arg, vecs[k].crc_byte};
            send_bits(f, 47, 0, 1);
            check_frame($sformatf("tab%0d", k), vecs[k].cmd, vecs[k].arg, vecs[k].exp_success);
        end

        // Result latency: DONE one clock after the end-bit strobe, verdict the clock after.
        f = {2'b01, 6'd0, 32'd0, 8'h95};
        send_bits(f, 47, 1, 1);
        @(negedge clk);
        win = {win[6:0], 1'b1};
        bus_if.io_InputBuffer = win;
        bus_if.io_BufferChanged = 1'b1;
        @(negedge clk);
        check("lat_state_done", 64'(bus_if.io____state), 64'd6);
        check("lat_success_pending", 64'(bus_if.io_ReadSuccess), 64'd0);
        bus_if.io_BufferChanged = 1'b0;
        @(negedge clk);
        check("lat_state_idle", 64'(bus_if.io____state), 64'd0);
        check("lat_success", 64'(bus_if.io_ReadSuccess), 64'd1);

        // Partial frame stops inside the CRC field.
        f = {2'b01, 6'h3B, 32'h0001_F791, 8'hFF};
        send_bits(f, 47, 2, 1);
        @(negedge clk);
        check("part_cmd", 64'(bus_if.io_Command), 64'h3B);
        check("part_arg", 64'(bus_if.io_CommandArgument), 64'h0001_F791);
        check("part_fin", 64'({bus_if.io_CommandReadFinished, bus_if.io_ArgumentReadFinished}), 64'd3);
        check("part_success", 64'(bus_if.io_ReadSuccess), 64'd0);
        check("part_state", 64'(bus_if.io____state), 64'd4);
        do_reset();

        // Framing error with a long-held changed flag.
        send_bit(1'b0, 3);
        send_bit(1'b0, 3);
        @(negedge clk);
        check("frame_err_state", 64'(bus_if.io____state), 64'd0);
        check("frame_err_flags", 64'({bus_if.io_CommandReadFinished, bus_if.io_ArgumentReadFinished,
                                      bus_if.io_ReadSuccess}), 64'd0);
        f = {2'b01, 6'd8, 32'h0000_01AA, 8'h87};
        send_bits(f, 47, 0, 3);
        check_frame("hold3", 6'd8, 32'h0000_01AA, 1'b1);

        // Reset in the middle of the argument field.
        f = {2'b01, 6'd17, 32'hDEAD_BEEF, 8'hFF};
        send_bits(f, 47, 30, 1);
        @(negedge clk);
        check("midarg_state", 64'(bus_if.io____state), 64'd3);
        do_reset();
        check_all_zero("midarg_reset");
        f = {2'b01, 6'd0, 32'd0, 8'h95};
        send_bits(f, 47, 0, 1);
        check_frame("after_reset", 6'd0, 32'd0, 1'b1);

        // Random frames: good CRC, corrupted CRC, or end bit 0.
        for (int n = 0; n < 24; n++) begin
            logic [5:0]  cmd;
            logic [31:0] arg;
            logic [6:0]  crc;
            logic        endb;
            int          mode;
            cmd  = 6'($urandom);
            arg  = $urandom;
            crc  = ref_crc7({2'b01, cmd, arg});
            mode = int'($urandom_range(0, 2));
            endb = 1'b1;
            if (mode == 1) crc = crc ^ 7'($urandom_range(1, 127));
            if (mode == 2) endb = 1'b0;
            bus_if.io_DataBlockSize = 8'($urandom);
            repeat ($urandom_range(0, 4)) send_bit(1'b1, 1);
            send_bits({2'b01, cmd, arg, crc, endb}, 47, 0, 0);
            check_frame($sformatf("rnd%0d", n), cmd, arg, (mode == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
